// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file bus definitions and types for the writeback port arbiter.
// The optional performance counter is enabled by defining WB_ARB_PERF_EN.
`ifndef WB_ARB_DEFINES
`define WB_ARB_DEFINES
`define RegBus        31:0
`define RegAddrBus    4:0
`define ZeroWord      32'h0000_0000
`define ZeroReg       5'h00
`define WriteEnable   1'b1
`define WriteDisable  1'b0
`define WbArbDepth    2
`endif

package wb_port_arbiter_pkg;

    localparam int WB_ARB_DEPTH = `WbArbDepth;

    typedef logic [`RegBus]     reg_word_t;
    typedef logic [`RegAddrBus] reg_addr_t;

    localparam reg_word_t ZERO_WORD = `ZeroWord;
    localparam reg_addr_t ZERO_REG  = `ZeroReg;

    // One queued long-latency result; valid=0 marks a squashed or x0 entry.
    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_word_t data;
    } llu_entry_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } starve_state_t;

    // True when a younger pipeline write to 'wr' makes a queued result for 'q' stale.
    function automatic logic waw_hit(input reg_addr_t wr, input reg_addr_t q);
        return (wr != ZERO_REG) && (wr == q);
    endfunction

endpackage

// File: rtl/wb_llu_fifo.sv
// Small FIFO of long-latency results with per-entry valid bits.
// Entries matching a younger pipeline write address are squashed in place,
// including an entry being pushed in that same cycle.
import wb_port_arbiter_pkg::*;

module wb_llu_fifo #(
    parameter int DEPTH = WB_ARB_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  reg_addr_t  push_addr_i,
    input  reg_word_t  push_data_i,
    input  logic       pop_i,
    input  logic       squash_i,
    input  reg_addr_t  squash_addr_i,
    output logic       full_o,
    output logic       empty_o,
    output llu_entry_t head_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    reg_addr_t         addr_q [DEPTH];
    reg_addr_t         addr_d [DEPTH];
    reg_word_t         data_q [DEPTH];
    reg_word_t         data_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [FILL_W-1:0] count_q, count_d;

    assign full_o  = (count_q == FILL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = '{valid: valid_q[rptr_q], addr: addr_q[rptr_q], data: data_q[rptr_q]};

    // Next-state: squash compare, pop, then push (push overrides a popped slot when full).
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (squash_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waw_hit(squash_addr_i, addr_q[i])) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (pop_i) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PTR_W'(1);
        end

        if (push_i) begin
            addr_d[wptr_q]  = push_addr_i;
            data_d[wptr_q]  = push_data_i;
            valid_d[wptr_q] = (push_addr_i != ZERO_REG) &&
                              !(squash_i && waw_hit(squash_addr_i, push_addr_i));
            wptr_d          = wptr_q + PTR_W'(1);
        end

        case ({push_i, pop_i})
            2'b10:   count_d = count_q + FILL_W'(1);
            2'b01:   count_d = count_q - FILL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; payload is not reset, only valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback always wins, queued
// long-latency results drain on idle cycles, and a starvation timer
// requests a one-cycle pipeline bubble. Optional perf counter: WB_ARB_PERF_EN.
//
// state     | meaning
// ST_RUN    | normal operation, starvation counter tracking blocked cycles
// ST_BUBBLE | stall_req_o asserted; pipeline idles so the FIFO head drains
import wb_port_arbiter_pkg::*;

module wb_port_arbiter #(
    parameter int DEPTH        = WB_ARB_DEPTH,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_waddr_i,
    input  logic [31:0] pipe_wdata_i,
    input  logic        llu_valid_i,
    input  logic [4:0]  llu_waddr_i,
    input  logic [31:0] llu_wdata_i,
    output logic        llu_ready_o,
    output logic        stall_req_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        busy_o
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0] conflict_cnt_o
`endif
);

    logic          fifo_full, fifo_empty;
    logic          push, pop, squash;
    llu_entry_t    head;
    starve_state_t state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // A pop frees a slot this cycle, so a full FIFO may still accept.
    assign pop         = !pipe_we_i && !fifo_empty;
    assign llu_ready_o = !fifo_full || pop;
    assign push        = llu_valid_i && llu_ready_o;
    assign squash      = pipe_we_i && (pipe_waddr_i != ZERO_REG);
    assign busy_o      = !fifo_empty;
    assign stall_req_o = (state_q == ST_BUBBLE);

    wb_llu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (push),
        .push_addr_i   (llu_waddr_i),
        .push_data_i   (llu_wdata_i),
        .pop_i         (pop),
        .squash_i      (squash),
        .squash_addr_i (pipe_waddr_i),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_o        (head)
    );

    // Write-port select: pipeline, else valid head, else nothing (squashed head pops silently).
    always_comb begin
        reg_we_o    = `WriteDisable;
        reg_waddr_o = ZERO_REG;
        reg_wdata_o = ZERO_WORD;
        if (pipe_we_i) begin
            reg_we_o    = `WriteEnable;
            reg_waddr_o = pipe_waddr_i;
            reg_wdata_o = pipe_wdata_i;
        end else if (!fifo_empty && head.valid) begin
            reg_we_o    = `WriteEnable;
            reg_waddr_o = head.addr;
            reg_wdata_o = head.data;
        end
    end

    // Starvation timer: counts blocked cycles, fires a single bubble on the limit.
    always_comb begin
        state_d      = ST_RUN;
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
            starve_cnt_d = '0;
            state_d      = ST_BUBBLE;
        end else begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    // Count cycles where the pipeline blocks a ready, valid head entry; saturates.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (pipe_we_i && !fifo_empty && head.valid && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    // Perf counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
